// File: rtl/seout_pkg.sv
// ---------------------------------------------------------------------------
// seout_pkg
//
// Shared definitions for the scatter-engine output / update write-back path.
// Holds the update word width, the padding word used to fill out a partial
// memory line at the end of a phase, the write-back controller state type and
// a small helper for sizing fill counters.
// ---------------------------------------------------------------------------
package seout_pkg;

  // Width of one serialized update word coming out of the scatter engine.
  localparam int WORD_W = 64;

  // Unused slots of a flushed partial line are filled with all-ones so that
  // the consumer can tell them apart from real updates.
  localparam logic [WORD_W-1:0] PAD_WORD = 64'hFFFF_FFFF_FFFF_FFFF;

  // Write-back controller phases.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } wb_state_e;

  // Bits needed to count 0..words inclusive (a full line is a legal count).
  function automatic int cntWidth(input int words);
    return $clog2(words + 1);
  endfunction

endpackage

// File: rtl/update_line_packer.sv
// ---------------------------------------------------------------------------
// update_line_packer
//
// Packing register for the update write-back path. Collects 64-bit update
// words into one memory line and exposes the line, already padded with
// PAD_WORD in every slot at or beyond the current fill count.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   clear_i  - discard any buffered words (start of a new phase)
//   push_i   - store word_i this cycle
//   word_i   - update word to store
//   take_i   - the current contents are being moved out this cycle
//   count_o  - number of valid words held (0..WORDS_PER_LINE)
//   line_o   - packed line, slot 0 in bits [63:0], padded past count_o
// ---------------------------------------------------------------------------
module update_line_packer
  import seout_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8,
  parameter int CNT_W          = cntWidth(WORDS_PER_LINE)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear_i,
  input  logic                             push_i,
  input  logic [WORD_W-1:0]                word_i,
  input  logic                             take_i,
  output logic [CNT_W-1:0]                 count_o,
  output logic [WORD_W*WORDS_PER_LINE-1:0] line_o
);

  logic [WORD_W-1:0] slot_q [WORDS_PER_LINE];
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  writeIdx;

  // Work out where an incoming word lands and what the fill count becomes.
  // When the line is taken in the same cycle a word arrives, that word is
  // the first word of the next line, so it goes to slot 0 and the count
  // restarts at 1 instead of 0.
  always_comb begin
    writeIdx = take_i ? '0 : count_q;
    count_d  = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (take_i) begin
      count_d = push_i ? CNT_W'(1) : '0;
    end else if (push_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Fill counter and word slots. Slots are compared against the write index
  // one by one rather than indexed directly, which keeps the index width
  // independent of the array depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        if (push_i && !clear_i && (writeIdx == CNT_W'(i))) begin
          slot_q[i] <= word_i;
        end
      end
    end
  end

  // Present the line with every slot that does not yet hold a real word
  // replaced by the pad pattern, so a flush can move it out unchanged.
  always_comb begin
    line_o = '0;
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      line_o[i*WORD_W +: WORD_W] = (CNT_W'(i) < count_q) ? slot_q[i] : PAD_WORD;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/update_wb_ctrl.sv
// ---------------------------------------------------------------------------
// update_wb_ctrl
//
// Write-back controller for serialized scatter-engine updates. Words arriving
// during a write phase are packed into memory lines, staged in a single output
// line register and written to memory over a valid/ready handshake at
// consecutive line addresses starting from the phase base address.
//
// Ports:
//   clk              - clock, rising edge
//   rst              - asynchronous active-high reset
//   start            - one-cycle pulse opening a phase, samples base_addr
//   base_addr        - byte address of the first line of the phase
//   input_word       - serialized update word
//   input_valid      - input_word valid this cycle
//   flush            - one-cycle pulse: no more updates in this phase
//   wr_addr          - byte address of the offered line
//   wr_data          - packed line, first received word in bits [63:0]
//   wr_valid         - output line register occupied
//   wr_ready         - memory accepts the line this cycle
//   se_stall_request - registered back-pressure to the scatter engine
//   done             - one-cycle pulse when the phase is fully written
//   lines_written    - lines accepted by memory in the current phase
//   overflow         - sticky: a word arrived with no free slot and was lost
// ---------------------------------------------------------------------------
module update_wb_ctrl
  import seout_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_W-1:0]                base_addr,
  input  logic [WORD_W-1:0]                input_word,
  input  logic                             input_valid,
  input  logic                             flush,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [WORD_W*WORDS_PER_LINE-1:0] wr_data,
  output logic                             wr_valid,
  input  logic                             wr_ready,
  output logic                             se_stall_request,
  output logic                             done,
  output logic [31:0]                      lines_written,
  output logic                             overflow
);

  localparam int                CNT_W      = cntWidth(WORDS_PER_LINE);
  localparam int                LINE_W     = WORD_W * WORDS_PER_LINE;
  localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0]  STALL_CNT  = CNT_W'(WORDS_PER_LINE - 2);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(8 * WORDS_PER_LINE);

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] nextAddr_q, nextAddr_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [LINE_W-1:0] wrData_q, wrData_d;
  logic              wrValid_q, wrValid_d;
  logic              stall_q, stall_d;
  logic              done_q, done_d;
  logic [31:0]       linesWritten_q, linesWritten_d;
  logic              overflow_q, overflow_d;

  logic [CNT_W-1:0]  fillCount;
  logic [LINE_W-1:0] packedLine;
  logic              handshake;
  logic              outFree;
  logic              packerFull;
  logic              take;
  logic              push;
  logic              dropWord;
  logic              clearPacker;

  // Decide this cycle's movements between input, packing register and output
  // register. The output register can accept a line when it is empty or when
  // its current line is being handed to memory in the same cycle. During FILL
  // only a completely full packing register is moved; during FLUSH whatever
  // is left is moved (the packer supplies the padding). A word arriving while
  // the packing register is full and cannot be moved has nowhere to go.
  always_comb begin
    handshake   = wrValid_q && wr_ready;
    outFree     = !wrValid_q || wr_ready;
    packerFull  = (fillCount == FULL_CNT);
    clearPacker = (state_q == ST_IDLE) && start;
    take        = 1'b0;
    if (state_q == ST_FILL) begin
      take = packerFull && outFree;
    end else if (state_q == ST_FLUSH) begin
      take = (fillCount != '0) && outFree;
    end
    push     = (state_q == ST_FILL) && input_valid && (!packerFull || take);
    dropWord = (state_q == ST_FILL) && input_valid && packerFull && !take;
  end

  update_line_packer #(
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .CNT_W          (CNT_W)
  ) uPacker (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clearPacker),
    .push_i  (push),
    .word_i  (input_word),
    .take_i  (take),
    .count_o (fillCount),
    .line_o  (packedLine)
  );

  // Phase sequencing. A flush pulse in FILL still lets a coincident word in
  // (it is handled by the push logic above), then FLUSH waits until the
  // leftover partial line has been moved to the output register. DRAIN ends
  // the phase once the output register is empty or emptying this cycle, so
  // done appears the cycle right after the last handshake.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (flush) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if ((fillCount == '0) || take) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outFree) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output line register, line addressing and phase status. A new line is
  // only loaded when the register is free, so data and address stay put for
  // as long as memory holds wr_ready low. The next line address simply
  // advances by one line per moved line and wraps naturally at ADDR_W bits.
  // The stall request looks at the packer being nearly full while the output
  // register is occupied; being registered, it leaves two words of slack.
  always_comb begin
    nextAddr_d     = nextAddr_q;
    wrAddr_d       = wrAddr_q;
    wrData_d       = wrData_q;
    wrValid_d      = wrValid_q;
    linesWritten_d = linesWritten_q;
    overflow_d     = overflow_q | dropWord;
    stall_d        = (fillCount >= STALL_CNT) && wrValid_q;

    if (clearPacker) begin
      nextAddr_d = base_addr;
    end

    if (take) begin
      wrValid_d  = 1'b1;
      wrData_d   = packedLine;
      wrAddr_d   = nextAddr_q;
      nextAddr_d = nextAddr_q + LINE_BYTES;
    end else if (handshake) begin
      wrValid_d = 1'b0;
    end

    if (clearPacker) begin
      linesWritten_d = '0;
    end else if (handshake) begin
      linesWritten_d = linesWritten_q + 32'd1;
    end
  end

  // State and output registers. Reset drops any partial or pending line and
  // returns to IDLE, so nothing is written until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      nextAddr_q     <= '0;
      wrAddr_q       <= '0;
      wrData_q       <= '0;
      wrValid_q      <= 1'b0;
      stall_q        <= 1'b0;
      done_q         <= 1'b0;
      linesWritten_q <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      nextAddr_q     <= nextAddr_d;
      wrAddr_q       <= wrAddr_d;
      wrData_q       <= wrData_d;
      wrValid_q      <= wrValid_d;
      stall_q        <= stall_d;
      done_q         <= done_d;
      linesWritten_q <= linesWritten_d;
      overflow_q     <= overflow_d;
    end
  end

  assign wr_addr          = wrAddr_q;
  assign wr_data          = wrData_q;
  assign wr_valid         = wrValid_q;
  assign se_stall_request = stall_q;
  assign done             = done_q;
  assign lines_written    = linesWritten_q;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_update_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_update_wb_ctrl
//
// Self-checking bench for update_wb_ctrl. A reference model packs driven
// words into expected lines and pushes them on a scoreboard; a monitor pops
// and compares each line when memory accepts it.
// ---------------------------------------------------------------------------
module tb_update_wb_ctrl;

  localparam int W  = 8;
  localparam int AW = 32;
  localparam int LW = 64 * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [63:0]   input_word = '0;
  logic          input_valid = 1'b0;
  logic          flush = 1'b0;
  logic          wr_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_data;
  logic          wr_valid;
  logic          se_stall_request;
  logic          done;
  logic [31:0]   lines_written;
  logic          overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastHsCyc = -1;

  logic [AW-1:0] expAddrQ[$];
  logic [LW-1:0] expDataQ[$];

  logic [AW-1:0] mBase;
  int            mIdx;
  int            mCount;
  logic [63:0]   mWords [W];

  logic          heldValid = 1'b0;
  logic [AW-1:0] heldAddr;
  logic [LW-1:0] heldData;
  logic [AW-1:0] popAddr;
  logic [LW-1:0] popData;

  update_wb_ctrl #(
    .WORDS_PER_LINE (W),
    .ADDR_W         (AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .base_addr        (base_addr),
    .input_word       (input_word),
    .input_valid      (input_valid),
    .flush            (flush),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .se_stall_request (se_stall_request),
    .done             (done),
    .lines_written    (lines_written),
    .overflow         (overflow)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Line monitor on the falling edge: checks the offered line stays frozen
  // while stalled, and compares every accepted line with the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      heldValid = 1'b0;
    end else begin
      if (heldValid && wr_valid) begin
        checks++;
        if ((wr_addr !== heldAddr) || (wr_data !== heldData)) begin
          errors++;
          $display("[TB] FAIL stable_while_stalled: got addr %h, expected %h", wr_addr, heldAddr);
        end
      end
      if (wr_valid && wr_ready) begin
        lastHsCyc = cyc;
        checks++;
        if (expAddrQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got write at %h, expected none", wr_addr);
        end else begin
          popAddr = expAddrQ.pop_front();
          popData = expDataQ.pop_front();
          if (wr_addr !== popAddr) begin
            errors++;
            $display("[TB] FAIL line_addr: got %h, expected %h", wr_addr, popAddr);
          end
          checks++;
          if (wr_data !== popData) begin
            errors++;
            $display("[TB] FAIL line_data: got %h, expected %h", wr_data, popData);
          end
        end
      end
      heldValid = wr_valid && !wr_ready;
      heldAddr  = wr_addr;
      heldData  = wr_data;
    end
  end

  // ---------------- reference model ----------------
  task automatic modelStart(input logic [AW-1:0] b);
    mBase  = b;
    mIdx   = 0;
    mCount = 0;
  endtask

  task automatic pushLine();
    logic [LW-1:0] line;
    for (int i = 0; i < W; i++) begin
      line[i*64 +: 64] = (i < mCount) ? mWords[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    end
    expAddrQ.push_back(mBase + AW'(mIdx * 8 * W));
    expDataQ.push_back(line);
    mIdx++;
    mCount = 0;
  endtask

  task automatic modelWord(input logic [63:0] w);
    mWords[mCount] = w;
    mCount++;
    if (mCount == W) pushLine();
  endtask

  task automatic modelFlush();
    if (mCount > 0) pushLine();
  endtask

  task automatic clearModel();
    expAddrQ.delete();
    expDataQ.delete();
    mCount = 0;
    mIdx   = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doStart(input logic [AW-1:0] b);
    base_addr = b;
    start     = 1'b1;
    modelStart(b);
    tick();
    start = 1'b0;
  endtask

  task automatic sendWord(input logic [63:0] w, input bit withFlush, input bit modelIt);
    input_word  = w;
    input_valid = 1'b1;
    flush       = withFlush;
    if (modelIt) modelWord(w);
    if (withFlush) modelFlush();
    tick();
    input_valid = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic sendFlush();
    flush = 1'b1;
    modelFlush();
    tick();
    flush = 1'b0;
  endtask

  task automatic waitDone(input string name, output int doneCyc);
    bit seen;
    seen    = 1'b0;
    doneCyc = -1;
    for (int i = 0; i < 80 && !seen; i++) begin
      if (done === 1'b1) begin
        seen    = 1'b1;
        doneCyc = cyc;
      end else begin
        tick();
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL %s_done: got no done pulse, expected one", name);
    end else begin
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s_done_width: got done=%b, expected 0", name, done);
      end
    end
  endtask

  task automatic checkDrained(input string name);
    checks++;
    if (expAddrQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drained: got %0d lines pending, expected 0", name, expAddrQ.size());
    end
  endtask

  task automatic checkLines(input string name, input logic [31:0] exp);
    checks++;
    if (lines_written !== exp) begin
      errors++;
      $display("[TB] FAIL %s_lines_written: got %0d, expected %0d", name, lines_written, exp);
    end
  endtask

  task automatic checkAllZero(input string name);
    checks++;
    if (wr_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_wr_valid: got %b, expected 0", name, wr_valid); end
    checks++;
    if (wr_data !== '0) begin errors++; $display("[TB] FAIL %s_wr_data: got %h, expected 0", name, wr_data); end
    checks++;
    if (wr_addr !== '0) begin errors++; $display("[TB] FAIL %s_wr_addr: got %h, expected 0", name, wr_addr); end
    checks++;
    if (se_stall_request !== 1'b0) begin errors++; $display("[TB] FAIL %s_stall: got %b, expected 0", name, se_stall_request); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s_done: got %b, expected 0", name, done); end
    checks++;
    if (lines_written !== 32'd0) begin errors++; $display("[TB] FAIL %s_lines_written: got %0d, expected 0", name, lines_written); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL %s_overflow: got %b, expected 0", name, overflow); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask

  task automatic test_two_lines();
    int dc;
    wr_ready = 1'b1;
    doStart(32'h0000_1000);
    for (int i = 1; i <= 16; i++) sendWord(64'(i), 1'b0, 1'b1);
    sendFlush();
    waitDone("two_lines", dc);
    checkLines("two_lines", 32'd2);
    checkDrained("two_lines");
  endtask

  task automatic test_partial_flush();
    int dc;
    wr_ready = 1'b1;
    doStart(32'h0000_3000);
    for (int i = 0; i < 5; i++) sendWord(64'h0A + 64'(i), 1'b0, 1'b1);
    sendFlush();
    waitDone("partial", dc);
    checks++;
    if (dc != lastHsCyc + 1) begin
      errors++;
      $display("[TB] FAIL partial_done_timing: got done in cycle %0d, expected cycle %0d", dc, lastHsCyc + 1);
    end
    checkLines("partial", 32'd1);
    checkDrained("partial");
  endtask

  task automatic test_empty_flush();
    int dc;
    wr_ready = 1'b1;
    doStart(32'h0000_9000);
    sendFlush();
    waitDone("empty", dc);
    checkLines("empty", 32'd0);
  endtask

  task automatic test_stall_honored();
    int  dc;
    int  sent;
    bit  stallSeen;
    bit  cleared;
    wr_ready  = 1'b0;
    doStart(32'h0000_5000);
    sent      = 0;
    stallSeen = 1'b0;
    for (int i = 0; i < 40 && !stallSeen; i++) begin
      if (se_stall_request === 1'b1) stallSeen = 1'b1;
      else begin
        sendWord(64'(sent + 1), 1'b0, 1'b1);
        sent++;
      end
    end
    checks++;
    if (!stallSeen || sent != 15) begin
      errors++;
      $display("[TB] FAIL stall_assert: got stall=%b after %0d words, expected 1 after 15", stallSeen, sent);
    end
    repeat (5) tick();
    checks++;
    if (se_stall_request !== 1'b1) begin
      errors++;
      $display("[TB] FAIL stall_hold: got %b, expected 1", se_stall_request);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_honored_overflow: got %b, expected 0", overflow);
    end
    wr_ready = 1'b1;
    cleared  = 1'b0;
    for (int i = 0; i < 10 && !cleared; i++) begin
      if (se_stall_request === 1'b0) cleared = 1'b1;
      else tick();
    end
    checks++;
    if (!cleared) begin
      errors++;
      $display("[TB] FAIL stall_release: got stall=1, expected 0");
    end
    sendWord(64'd16, 1'b1, 1'b1);
    waitDone("stall_honored", dc);
    checkLines("stall_honored", 32'd2);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_honored_overflow_end: got %b, expected 0", overflow);
    end
    checkDrained("stall_honored");
  endtask

  task automatic test_wrap();
    int dc;
    wr_ready = 1'b1;
    doStart(32'hFFFF_FFC0);
    for (int i = 1; i <= 16; i++) sendWord(64'h100 + 64'(i), 1'b0, 1'b1);
    sendFlush();
    waitDone("wrap", dc);
    checkLines("wrap", 32'd2);
    checkDrained("wrap");
  endtask

  task automatic test_overflow();
    wr_ready = 1'b0;
    doStart(32'h0000_6000);
    for (int i = 1; i <= 16; i++) sendWord(64'(i), 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overflow_early: got %b, expected 0", overflow);
    end
    sendWord(64'd17, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_set: got %b, expected 1", overflow);
    end
    repeat (3) tick();
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_sticky: got %b, expected 1", overflow);
    end
  endtask

  task automatic test_reset_mid_line();
    int dc;
    int bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clearModel();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_clears_overflow: got %b, expected 0", overflow);
    end
    wr_ready = 1'b0;
    doStart(32'h0000_7000);
    for (int i = 1; i <= 11; i++) sendWord(64'h700 + 64'(i), 1'b0, 1'b1);
    checks++;
    if (wr_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_pending_line: got wr_valid=%b, expected 1", wr_valid);
    end
    #3 rst = 1'b1;
    #1;
    checkAllZero("mid_reset");
    clearModel();
    @(posedge clk);
    #1 rst = 1'b0;
    wr_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      input_valid = 1'b1;
      input_word  = {$urandom, $urandom};
      flush       = (i % 4 == 3);
      tick();
      if (wr_valid !== 1'b0) bad++;
    end
    input_valid = 1'b0;
    flush       = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL no_write_after_reset: got wr_valid high in %0d cycles, expected 0", bad);
    end
    doStart(32'h0000_8000);
    for (int i = 1; i <= 8; i++) sendWord(64'h800 + 64'(i), 1'b0, 1'b1);
    sendFlush();
    waitDone("recover", dc);
    checkLines("recover", 32'd1);
    checkDrained("recover");
  endtask

  initial begin
    test_reset();
    test_two_lines();
    test_partial_flush();
    test_empty_flush();
    test_stall_honored();
    test_wrap();
    test_overflow();
    test_reset_mid_line();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
